fifo_ctrl_dpr: RTL
==================

Name: fifo_ctrl_dpr

Overview:
Synchronous FIFO controller that drives the shared two-port, registered-output RAM block. Port A is the write path and port B is the read path. The controller owns the pointers, occupancy count, flags and read-latency alignment. It sits between a producer stream and a consumer stream; the RAM is instantiated alongside it at top level.

Parameters:
DATA_WIDTH, 8, data word width; matches the RAM data width.
ADDR_WIDTH, 3, RAM address width.
DEPTH, 8, FIFO entries; must equal 2**ADDR_WIDTH.
AFULL_THRESH, 6, count at or above which almost_full asserts; range 1..DEPTH.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous reset, active-high.
push  in  1  write request.
push_data  in  DATA_WIDTH  word to write.
pop  in  1  read request.
pop_data  out  DATA_WIDTH  read word; passthrough of ram_q_b.
pop_valid  out  1  pop_data valid this cycle.
full  out  1  count == DEPTH.
almost_full  out  1  count >= AFULL_THRESH.
empty  out  1  count == 0.
count  out  ADDR_WIDTH+1  current occupancy.
overflow  out  1  sticky: push seen while full and no pop.
underflow  out  1  sticky: pop seen while empty.
ram_ce  out  1  RAM chip enable; constant 1.
ram_we_a  out  1  RAM port A write enable.
ram_addr_a  out  ADDR_WIDTH  write pointer.
ram_data_a  out  DATA_WIDTH  equals push_data.
ram_we_b  out  1  RAM port B write enable; constant 0.
ram_addr_b  out  ADDR_WIDTH  read pointer.
ram_q_b  in  DATA_WIDTH  RAM port B registered read data.

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, overflow=0, underflow=0. This gives empty=1, full=0, almost_full=0.
- Reset mid-operation discards all contents. An in-flight read is dropped: pop_valid=0 the cycle after reset. RAM contents are not cleared.
- push_acc = push & (!full | pop). A push is accepted when full only if a pop is in the same cycle.
- pop_acc = pop & !empty.
- Write path: ram_we_a = push_acc, combinational. ram_addr_a = wr_ptr, ram_data_a = push_data. The RAM writes at this edge. wr_ptr increments mod DEPTH, wrapping from DEPTH-1 to 0.
- Read path: ram_addr_b = rd_ptr, combinational. On pop_acc, rd_ptr increments mod DEPTH. pop_valid is registered: pop_valid <= pop_acc.
- Read latency: 1 cycle. pop_data = ram_q_b is valid in the cycle after pop_acc, while pop_valid=1.
- count: +1 on push_acc only; -1 on pop_acc only; unchanged on both or neither. Flags are combinational from count.
- Simultaneous push+pop when full: both accepted and wr_ptr == rd_ptr. The RAM is read-first, so the old word is returned and the new word is stored. Count stays DEPTH.
- Simultaneous push+pop when empty: pop is rejected, push is accepted, count becomes 1. underflow sets.
- First-word latency: push at cycle N, pop at N+1 gives pop_data at N+2. No bypass path.
- overflow sets on push & full & !pop. underflow sets on pop & empty. Both are sticky until rst.
- Rejected requests never move pointers or count.

Decomposition:
- No package needed. Pointer width and count width derive from ADDR_WIDTH locally.
- Optional sub-module fifo_ptr: a mod-DEPTH incrementing pointer with enable and synchronous reset, instantiated twice (write and read pointers).
- The RAM is not instantiated inside this block. Integration is at top level: fifo_ctrl_dpr plus the dual-port RAM.

Test Plan:
1. Reset then idle → empty=1, full=0, count=0, pop_valid=0, overflow=0, underflow=0.
2. Push 8'h11..8'h18 (8 words), then pop 8 → full=1 after the 8th push; pop_data sequence 11..18, each one cycle after its pop; empty=1 at end.
3. Fill to full, push 8'hAA with pop=0 → overflow=1, count stays 8; the following pops return the original 8 words with no AA.
4. When full, push 8'h55 + pop in the same cycle → pop_data = oldest word (8'h11), count=8; after 7 more pops the 8th pop returns 8'h55.
5. Pop when empty → underflow=1, pop_valid=0, rd_ptr unchanged.
6. Wrap: push/pop 20 words continuously (1 per cycle, 1-cycle offset) → in-order data, count never exceeds 2; push 4 words, assert rst, then idle → empty=1 and pop_valid=0 the next cycle.

Source files
------------

// File: rtl/fifo_ptr.sv
// ============================================================================
// Module      : fifo_ptr
// Description : Mod-DEPTH incrementing pointer with enable and synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ptr #(
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    output logic [ADDR_WIDTH-1:0] ptr_o
);

    localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == C_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/fifo_ctrl_dpr.sv
// ============================================================================
// Module      : fifo_ctrl_dpr
// Description : Synchronous FIFO controller for an external two-port RAM with
//               registered, read-first port B output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ctrl_dpr #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_ce,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_AFULL = (ADDR_WIDTH + 1)'(AFULL_THRESH);

    logic [ADDR_WIDTH:0] count_q;
    logic [ADDR_WIDTH:0] count_d;
    logic                pop_valid_q;
    logic                overflow_q;
    logic                overflow_d;
    logic                underflow_q;
    logic                underflow_d;
    logic                push_acc;
    logic                pop_acc;

    assign full        = (count_q == C_DEPTH);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= C_AFULL);

    // A pop in the same cycle frees the slot the push needs, even when full.
    assign push_acc = push & (~full | pop);
    assign pop_acc  = pop & ~empty;

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q | (push & full & ~pop);
        underflow_d = underflow_q | (pop & empty);
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_valid_q <= pop_acc;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (push_acc),
        .ptr_o (ram_addr_a)
    );

    fifo_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (pop_acc),
        .ptr_o (ram_addr_b)
    );

    // Read data comes straight from the RAM's output register; no bypass.
    assign pop_data   = ram_q_b;
    assign pop_valid  = pop_valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign ram_ce     = 1'b1;
    assign ram_we_a   = push_acc;
    assign ram_data_a = push_data;
    assign ram_we_b   = 1'b0;

endmodule

`default_nettype wire
